// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings and burst helpers.
//   htrans / hburst / hresp encodings as sized localparams.
//   burst_beats_m1 : hburst -> number of beats minus one (0 for SINGLE/INCR).
//   burst_is_fixed : hburst is a fixed-length (WRAPx/INCRx) burst.
package ahb_pkg;

  typedef logic [1:0] htrans_t;
  typedef logic [2:0] hburst_t;
  typedef logic [1:0] hresp_t;

  localparam htrans_t HTRANS_IDLE   = 2'd0;
  localparam htrans_t HTRANS_BUSY   = 2'd1;
  localparam htrans_t HTRANS_NONSEQ = 2'd2;
  localparam htrans_t HTRANS_SEQ    = 2'd3;

  localparam hburst_t HBURST_SINGLE = 3'd0;
  localparam hburst_t HBURST_INCR   = 3'd1;
  localparam hburst_t HBURST_WRAP4  = 3'd2;
  localparam hburst_t HBURST_INCR4  = 3'd3;
  localparam hburst_t HBURST_WRAP8  = 3'd4;
  localparam hburst_t HBURST_INCR8  = 3'd5;
  localparam hburst_t HBURST_WRAP16 = 3'd6;
  localparam hburst_t HBURST_INCR16 = 3'd7;

  localparam hresp_t HRESP_OKAY  = 2'd0;
  localparam hresp_t HRESP_ERROR = 2'd1;
  localparam hresp_t HRESP_RETRY = 2'd2;
  localparam hresp_t HRESP_SPLIT = 2'd3;

  function automatic logic [3:0] burst_beats_m1(input hburst_t hb);
    logic [3:0] n;
    case (hb)
      HBURST_WRAP4,  HBURST_INCR4:  n = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  n = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: n = 4'd15;
      default:                      n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic burst_is_fixed(input hburst_t hb);
    return (hb >= HBURST_WRAP4);
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick: combinational rotate-priority picker.
//   req   [N-1:0]  request vector
//   ptr   [PW-1:0] index of the last winner; it gets lowest priority
//   grant [N-1:0]  one-hot winner (all zero when no request)
//   valid          at least one request present
// Search order is ptr+1, ptr+2, ... wrapping, ending at ptr itself.
module ahb_rr_pick #(
  parameter int N  = 16,
  parameter int PW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((32'(ptr) + 32'(i)) % 32'(N));
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: round-robin AHB bus arbiter.
//   hclk, hresetn         clock, async active-low reset
//   hbusreq, hlock        per-master request / locked-access request
//   htrans, hburst        current transfer type / burst type on the bus
//   hready, hresp         shared transfer-done / response
//   hgrant                one-hot grant (registered)
//   hmaster, hmastlock    owner and lock of the current address phase
//
// State registers:
//   hgrant      | master granted for the next address phase
//   ptr         | last round-robin winner (lowest priority next time)
//   beats_left  | remaining beats of a fixed-length burst, minus one
//   lock_hold   | granted master held a locked transfer last hready cycle
module ahb_rr_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 16,
  parameter int MW             = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock
);

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

  logic [MW-1:0]          ptr;
  logic [3:0]             beats_left;
  logic                   lock_hold;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic                   pick_valid;
  logic [MW-1:0]          grant_idx;
  logic [MW-1:0]          win_idx;
  logic                   lock_g;
  logic                   fixed_nonseq;
  logic                   arb_en;
  logic                   split_retry;

  ahb_rr_pick #(
    .N  (NUM_MASTERS),
    .PW (MW)
  ) u_pick (
    .req   (hbusreq),
    .ptr   (ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  always_comb begin
    grant_idx = '0;
    win_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant[i])     grant_idx = MW'(i);
      if (pick_grant[i]) win_idx   = MW'(i);
    end
  end

  assign lock_g       = |(hlock & hgrant);
  assign fixed_nonseq = (htrans == HTRANS_NONSEQ) && burst_is_fixed(hburst);
  // Grant may only move on the last beat of a fixed burst (beats_left==1)
  // or when no fixed burst is running (beats_left==0).
  assign arb_en       = hready && !lock_hold && (beats_left <= 4'd1) && !fixed_nonseq;
  assign split_retry  = (hresp == HRESP_RETRY) || (hresp == HRESP_SPLIT);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hgrant     <= DEF_GRANT;
      hmaster    <= DEF_IDX;
      hmastlock  <= 1'b0;
      ptr        <= DEF_IDX;
      beats_left <= 4'd0;
      lock_hold  <= 1'b0;
    end else if (hready) begin
      hmaster   <= grant_idx;
      hmastlock <= lock_g;
      lock_hold <= lock_g;

      if (htrans == HTRANS_NONSEQ)
        beats_left <= burst_beats_m1(hburst);
      else if ((htrans == HTRANS_SEQ) && (beats_left != 4'd0))
        beats_left <= beats_left - 4'd1;

      if (arb_en) begin
        if (pick_valid) begin
          hgrant <= pick_grant;
          ptr    <= win_idx;
        end else begin
          hgrant <= DEF_GRANT;
        end
      end
    end else if (split_retry) begin
      // First cycle of a two-cycle RETRY/SPLIT: abandon the burst and lock
      // so the following hready cycle re-arbitrates with the owner last.
      beats_left <= 4'd0;
      lock_hold  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
module tb_ahb_rr_arbiter;
  import ahb_pkg::*;

  localparam int NM = 16;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [15:0] hbusreq;
  logic [15:0] hlock;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic        hready;
  logic [1:0]  hresp;
  logic [15:0] hgrant;
  logic [3:0]  hmaster;
  logic        hmastlock;

  int total = 0;
  int bad   = 0;

  // Reference model state, in plain integers.
  int m_grant, m_master, m_ptr, m_beats;
  bit m_mlock, m_lockhold;

  logic [15:0] rr_g [6] = '{16'h0002, 16'h0004, 16'h0020, 16'h0002, 16'h0004, 16'h0020};
  logic [15:0] rr_m [6] = '{16'd0, 16'd1, 16'd2, 16'd5, 16'd1, 16'd2};

  ahb_rr_arbiter #(
    .NUM_MASTERS    (NM),
    .MW             (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  always #5 hclk = ~hclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int burst_len(input logic [2:0] hb);
    if (hb < 3'd2) return 1;
    return 4 << ((int'(hb) - 2) / 2);
  endfunction

  task automatic model_reset();
    m_grant = 0; m_master = 0; m_mlock = 0;
    m_ptr = 0; m_beats = 0; m_lockhold = 0;
  endtask

  task automatic model_edge();
    int  g_old;
    int  winner;
    bit  arb;
    g_old = m_grant;
    if (hready) begin
      arb = !m_lockhold && (m_beats <= 1) && !(htrans == 2'd2 && hburst >= 3'd2);
      m_master   = g_old;
      m_mlock    = hlock[g_old[3:0]];
      m_lockhold = m_mlock;
      if (htrans == 2'd2) m_beats = burst_len(hburst) - 1;
      else if (htrans == 2'd3 && m_beats > 0) m_beats--;
      if (arb) begin
        winner = -1;
        for (int k = 1; k <= NM; k++) begin
          int c;
          c = (m_ptr + k) % NM;
          if (winner < 0 && hbusreq[c[3:0]]) winner = c;
        end
        if (winner >= 0) begin
          m_grant = winner;
          m_ptr   = winner;
        end else begin
          m_grant = 0;
        end
      end
    end else if (hresp >= 2'd2) begin
      m_beats    = 0;
      m_lockhold = 0;
    end
  endtask

  task automatic compare(input string tag);
    check({tag, "/grant"},  hgrant, 16'(1) << m_grant);
    check({tag, "/master"}, {12'b0, hmaster}, 16'(m_master));
    check({tag, "/lock"},   {15'b0, hmastlock}, {15'b0, m_mlock});
    check({tag, "/onehot"}, {15'b0, $onehot(hgrant)}, 16'd1);
  endtask

  task automatic step(input string tag);
    @(posedge hclk);
    model_edge();
    #1;
    compare(tag);
  endtask

  task automatic drive(input logic [15:0] req, input logic [15:0] lk, input logic [1:0] tr,
                       input logic [2:0] hb, input logic rdy, input logic [1:0] rsp);
    hbusreq = req; hlock = lk; htrans = tr; hburst = hb; hready = rdy; hresp = rsp;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    hresetn = 1'b0;
    #2;
    check({tag, "/rst_grant"},  hgrant, 16'h0001);
    check({tag, "/rst_master"}, {12'b0, hmaster}, 16'd0);
    check({tag, "/rst_lock"},   {15'b0, hmastlock}, 16'd0);
    model_reset();
    hresetn = 1'b1;
  endtask

  initial begin
    drive(16'h0000, 16'h0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
    hresetn = 1'b0;
    model_reset();
    #12;
    hresetn = 1'b1;

    // Round-robin over masters 1, 2, 5.
    drive(16'h0026, 16'h0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY);
    for (int i = 0; i < 6; i++) begin
      step("rr");
      check("rr_grant_seq",  hgrant, rr_g[i]);
      check("rr_master_seq", {12'b0, hmaster}, rr_m[i]);
    end
    pulse_reset("rst_mid");

    // INCR4 from master 2, master 5 waiting.
    drive(16'h0004, 16'h0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
    step("b_own");
    check("b_own_grant", hgrant, 16'h0004);
    drive(16'h0024, 16'h0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, HRESP_OKAY);
    step("b_beat1");
    check("b_beat1_grant", hgrant, 16'h0004);
    htrans = HTRANS_SEQ;
    step("b_beat2");
    check("b_beat2_grant", hgrant, 16'h0004);
    step("b_beat3");
    check("b_beat3_grant", hgrant, 16'h0004);
    step("b_beat4");
    check("b_beat4_grant", hgrant, 16'h0020);
    check("b_beat4_master", {12'b0, hmaster}, 16'd2);
    drive(16'h0020, 16'h0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
    step("b_after");
    check("b_after_master", {12'b0, hmaster}, 16'd5);
    pulse_reset("rst_b");

    // Same burst with 3 wait states on beat 2.
    drive(16'h0004, 16'h0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
    step("w_own");
    drive(16'h0024, 16'h0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, HRESP_OKAY);
    step("w_beat1");
    htrans = HTRANS_SEQ;
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("w_wait");
      check("w_wait_grant", hgrant, 16'h0004);
    end
    hready = 1'b1;
    step("w_beat2");
    check("w_beat2_grant", hgrant, 16'h0004);
    step("w_beat3");
    check("w_beat3_grant", hgrant, 16'h0004);
    step("w_beat4");
    check("w_beat4_grant", hgrant, 16'h0020);
    pulse_reset("rst_w");

    // Locked INCR from master 3, master 0 waiting.
    drive(16'h0008, 16'h0008, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
    step("l_own");
    step("l_own2");
    check("l_own_grant", hgrant, 16'h0008);
    drive(16'h0009, 16'h0008, HTRANS_NONSEQ, HBURST_INCR, 1'b1, HRESP_OKAY);
    step("l_nonseq");
    check("l_nonseq_grant", hgrant, 16'h0008);
    check("l_nonseq_mlock", {15'b0, hmastlock}, 16'd1);
    htrans = HTRANS_SEQ;
    for (int i = 0; i < 3; i++) begin
      step("l_seq");
      check("l_seq_grant", hgrant, 16'h0008);
      check("l_seq_mlock", {15'b0, hmastlock}, 16'd1);
    end
    hlock = 16'h0000;
    step("l_drop");
    check("l_drop_grant", hgrant, 16'h0008);
    step("l_hand");
    check("l_hand_grant", hgrant, 16'h0001);
    pulse_reset("rst_l");

    // SPLIT in the middle of an INCR8 from master 7.
    drive(16'h0080, 16'h0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
    step("s_own");
    check("s_own_grant", hgrant, 16'h0080);
    drive(16'h0082, 16'h0000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1, HRESP_OKAY);
    step("s_beat1");
    htrans = HTRANS_SEQ;
    step("s_beat2");
    step("s_beat3");
    check("s_beat3_grant", hgrant, 16'h0080);
    hready = 1'b0;
    hresp  = HRESP_SPLIT;
    step("s_resp1");
    check("s_resp1_grant", hgrant, 16'h0080);
    hready = 1'b1;
    htrans = HTRANS_IDLE;
    step("s_resp2");
    check("s_resp2_grant", hgrant, 16'h0002);
    hresp = HRESP_OKAY;
    step("s_after");
    pulse_reset("rst_s");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 4000; n++) begin
      hbusreq = 16'($urandom & $urandom);
      hlock   = 16'($urandom & $urandom & $urandom);
      htrans  = 2'($urandom_range(0, 3));
      hburst  = 3'($urandom_range(0, 7));
      hready  = ($urandom_range(0, 3) != 0);
      hresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : HRESP_OKAY;
      if ($urandom_range(0, 299) == 0) pulse_reset("rnd_rst");
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
- Bus arbiter for the multi-master AHB fabric. Sits between the masters' request lines and the master-side address/write-data muxes.
- Shares one AHB address/data bus among NUM_MASTERS requesters using round-robin priority.
- Honours fixed-length bursts, locked transfers and RETRY/SPLIT responses.
- Drives the one-hot grants, the hmaster select for the master mux and the decoder, and hmastlock.

Parameters:
- NUM_MASTERS, 16, number of requesting masters (2..16).
- MW, 4, width of hmaster; must satisfy 2**MW >= NUM_MASTERS.
- DEFAULT_MASTER, 0, master index granted when nobody requests.

Ports:
- hclk  in  1  AHB clock.
- hresetn  in  1  asynchronous active-low reset.
- hbusreq  in  NUM_MASTERS  per-master bus request.
- hlock  in  NUM_MASTERS  per-master locked-access request.
- htrans  in  2  transfer type on the shared bus (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst  in  3  burst type on the shared bus (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- hready  in  1  shared transfer-done.
- hresp  in  2  shared response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
- hgrant  out  NUM_MASTERS  one-hot grant.
- hmaster  out  MW  index of the master owning the current address phase.
- hmastlock  out  1  current address phase is locked.

Behaviour:
- Reset (hresetn low, asynchronous):
  - hgrant = one-hot DEFAULT_MASTER; hmaster = DEFAULT_MASTER; hmastlock = 0.
  - Priority pointer = DEFAULT_MASTER; beats_left = 0; lock_hold = 0.
- All state updates on the rising edge of hclk, and only in cycles with hready=1, with one exception: the RETRY/SPLIT release below.
- Address-phase tracking (hready=1):
  - hmaster <= index(hgrant); hmastlock <= hlock[index(hgrant)].
  - hmaster therefore lags hgrant by one hready-qualified cycle.
- Burst counter beats_left, 4 bits:
  - htrans=NONSEQ & hready: load length-1 (WRAP4/INCR4→3, WRAP8/INCR8→7, WRAP16/INCR16→15, SINGLE/INCR→0).
  - htrans=SEQ & hready & beats_left>0: decrement.
  - IDLE/BUSY: hold.
- lock_hold: set when hready=1 and hlock[granted] is 1; cleared when hready=1 and hlock[granted] is 0.
- Arbitration enable arb_en = hready & !lock_hold & (beats_left <= 1) & !(htrans==NONSEQ & fixed-length burst).
  - Result: the grant moves during the final beat's address phase.
  - INCR and SINGLE re-arbitrate every hready cycle.
- Round-robin selection when arb_en:
  - Search hbusreq starting at (pointer+1) mod NUM_MASTERS, wrapping; the first requester wins.
  - Pointer <= winner.
  - No requester: grant DEFAULT_MASTER; pointer unchanged.
  - If the current owner is the only requester, it keeps the grant.
- When arb_en=0, hgrant holds.
- RETRY/SPLIT release:
  - hresp in {RETRY, SPLIT} with hready=0 (first response cycle): beats_left <= 0 and lock_hold <= 0.
  - The next hready cycle then re-arbitrates; the current owner is lowest priority.
- ERROR response: no special action; the burst counter continues as driven.
- Invariants:
  - hgrant is always exactly one-hot.
  - Bits of hbusreq/hlock at indices >= NUM_MASTERS are ignored.
  - The grant never changes while hready=0.
- Reset mid-burst: immediate return to the reset state; no grant glitch other than the asynchronous jump to DEFAULT_MASTER.

Decomposition:
- Package ahb_pkg: htrans, hburst and hresp encodings as localparams/typedefs; a burst-length lookup function (hburst → beats-1).
- One natural sub-module: ahb_rr_pick, a combinational rotate-priority picker (request vector + pointer → one-hot winner + valid). It is reusable by the slave-side mux sequencing.

Test Plan:
- Reset: hresetn=0 mid-run → hgrant=16'h0001, hmaster=0, hmastlock=0 asynchronously, with no clock edge needed.
- Round-robin: hbusreq=16'h0026 held, SINGLE transfers, hready=1 → grants cycle 1→2→5→1… in successive NONSEQ cycles; hmaster follows one cycle later.
- Fixed burst: master 2 issues INCR4, master 5 requests from beat 1 → hgrant stays on bit 2 until the 4th beat's address phase, then moves to bit 5; hmaster=5 on the following cycle.
- Wait states: the same INCR4 with hready=0 for 3 cycles on beat 2 → grant and beats_left frozen; handover is delayed exactly 3 cycles.
- Lock: master 3 asserts hlock with INCR, master 0 requests → hgrant stays on master 3 and hmastlock=1 while hlock[3]=1; handover occurs on the first hready cycle after hlock[3] drops.
- SPLIT: master 7 mid-INCR8 receives SPLIT (hready=0, then 1), master 1 requests → hgrant moves to master 1 on the hready=1 response cycle.
